// File: rtl/bht_access_scheduler.sv
// bht_access_scheduler: arbitrates the single BHT port between fetch lookups
// (reads) and buffered execute-stage updates (writes), and runs a clear sweep
// over the whole table after reset or flush.
// Optional feature macro: BHT_PENDING_HIT_EN adds the lookup_pending output.
module bht_access_scheduler #(
   parameter int unsigned LOWER    = 5,
   parameter int unsigned QDEPTH   = 4,
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          lookup_valid,
   input  logic [LOWER-1:0]              lookup_idx,
   output logic                          lookup_ready,
   input  logic                          resolve_valid,
   input  logic [LOWER-1:0]              resolve_idx,
   input  logic                          resolve_taken,
   output logic                          resolve_ready,
   output logic                          bht_en,
   output logic                          bht_we,
   output logic                          bht_clear,
   output logic [LOWER-1:0]              bht_addr,
   output logic                          bht_taken,
   output logic                          init_done,
`ifdef BHT_PENDING_HIT_EN
   output logic                          lookup_pending,
`endif
   output logic [$clog2(QDEPTH+1)-1:0]   q_count
);

   localparam int unsigned CNT_W  = $clog2(QDEPTH+1);
   localparam int unsigned PTR_W  = $clog2(QDEPTH);
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT+1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t              state_q, state_d;
   logic [LOWER-1:0]    sweep_q, sweep_d;
   logic [PTR_W-1:0]    head_q, head_d;
   logic [PTR_W-1:0]    tail_q, tail_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [LOWER-1:0]    fifo_idx_q [QDEPTH];
   logic [LOWER-1:0]    fifo_idx_d [QDEPTH];
   logic                fifo_tk_q  [QDEPTH];
   logic                fifo_tk_d  [QDEPTH];

   logic                force_wr;
   logic                wr_grant;
   logic                rd_grant;
   logic                push;

   // Arbitration, FIFO bookkeeping, sweep sequencing and port outputs.
   always_comb begin
      state_d       = state_q;
      sweep_d       = sweep_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      wait_d        = wait_q;
      fifo_idx_d    = fifo_idx_q;
      fifo_tk_d     = fifo_tk_q;
      force_wr      = 1'b0;
      wr_grant      = 1'b0;
      rd_grant      = 1'b0;
      push          = 1'b0;
      lookup_ready  = 1'b0;
      resolve_ready = 1'b0;
      bht_en        = 1'b0;
      bht_we        = 1'b0;
      bht_clear     = 1'b0;
      bht_addr      = '0;
      bht_taken     = 1'b0;
      init_done     = (state_q == ST_RUN);
      q_count       = count_q;

      case (state_q)
         ST_INIT: begin
            if (!flush) begin
               bht_en    = 1'b1;
               bht_we    = 1'b1;
               bht_clear = 1'b1;
               bht_addr  = sweep_q;
               sweep_d   = sweep_q + LOWER'(1);
               if (sweep_q == '1) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            force_wr = (count_q != '0) &&
                       ((count_q == CNT_W'(QDEPTH)) || (wait_q == WAIT_W'(MAX_WAIT)));
            if (!flush) begin
               lookup_ready  = !force_wr;
               resolve_ready = (count_q < CNT_W'(QDEPTH));
               wr_grant      = force_wr || ((count_q != '0) && !lookup_valid);
               rd_grant      = !wr_grant && lookup_valid;
               push          = resolve_valid && resolve_ready;

               if (wr_grant) begin
                  bht_en    = 1'b1;
                  bht_we    = 1'b1;
                  bht_addr  = fifo_idx_q[head_q];
                  bht_taken = fifo_tk_q[head_q];
                  head_d    = head_q + PTR_W'(1);
               end else if (rd_grant) begin
                  bht_en   = 1'b1;
                  bht_addr = lookup_idx;
               end

               if (push) begin
                  fifo_idx_d[tail_q] = resolve_idx;
                  fifo_tk_d[tail_q]  = resolve_taken;
                  tail_d             = tail_q + PTR_W'(1);
               end

               if (push && !wr_grant) begin
                  count_d = count_q + CNT_W'(1);
               end else if (!push && wr_grant) begin
                  count_d = count_q - CNT_W'(1);
               end

               if (wr_grant || (count_q == '0)) begin
                  wait_d = '0;
               end else if (rd_grant && (wait_q != WAIT_W'(MAX_WAIT))) begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
         end
         default: state_d = ST_INIT;
      endcase

      if (flush) begin
         state_d = ST_INIT;
         sweep_d = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         wait_d  = '0;
      end

      if (rst) begin
         lookup_ready  = 1'b0;
         resolve_ready = 1'b0;
         bht_en        = 1'b0;
         bht_we        = 1'b0;
         bht_clear     = 1'b0;
         bht_addr      = '0;
         bht_taken     = 1'b0;
         init_done     = 1'b0;
         q_count       = '0;
      end
   end

`ifdef BHT_PENDING_HIT_EN
   // Flag an accepted lookup whose index still has an update waiting in the FIFO.
   always_comb begin
      lookup_pending = 1'b0;
      if ((state_q == ST_RUN) && lookup_valid && lookup_ready && !rst) begin
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (fifo_idx_q[head_q + PTR_W'(i)] == lookup_idx)) begin
               lookup_pending = 1'b1;
            end
         end
      end
   end
`endif

   // State, pointer and FIFO storage registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         sweep_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         wait_q     <= '0;
         fifo_idx_q <= '{default: '0};
         fifo_tk_q  <= '{default: 1'b0};
      end else begin
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         wait_q     <= wait_d;
         fifo_idx_q <= fifo_idx_d;
         fifo_tk_q  <= fifo_tk_d;
      end
   end

endmodule

// File: tb/tb_bht_access_scheduler.sv
// Bench for bht_access_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_bht_access_scheduler;

   localparam int LOWER    = 5;
   localparam int QDEPTH   = 4;
   localparam int MAX_WAIT = 3;
   localparam int ENTRIES  = 32;

   logic       clk = 1'b0;
   logic       rst, flush, lookup_valid, resolve_valid, resolve_taken;
   logic [4:0] lookup_idx, resolve_idx;
   logic       lookup_ready, resolve_ready, bht_en, bht_we, bht_clear, bht_taken, init_done;
   logic [4:0] bht_addr;
   logic [2:0] q_count;
`ifdef BHT_PENDING_HIT_EN
   logic       lookup_pending;
`endif

   bht_access_scheduler #(.LOWER(LOWER), .QDEPTH(QDEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .lookup_valid(lookup_valid), .lookup_idx(lookup_idx), .lookup_ready(lookup_ready),
      .resolve_valid(resolve_valid), .resolve_idx(resolve_idx),
      .resolve_taken(resolve_taken), .resolve_ready(resolve_ready),
      .bht_en(bht_en), .bht_we(bht_we), .bht_clear(bht_clear), .bht_addr(bht_addr),
      .bht_taken(bht_taken), .init_done(init_done),
`ifdef BHT_PENDING_HIT_EN
      .lookup_pending(lookup_pending),
`endif
      .q_count(q_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [4:0] idx; logic taken;} ent_t;

   // reference model state
   ent_t       mq[$];
   bit         m_run;
   int         m_sweep;
   int         m_wait;
   // expected outputs for the current cycle
   bit         e_en, e_we, e_clr, e_tk, e_lr, e_rr, e_done, e_pend, m_wr, m_rd;
   logic [4:0] e_addr;
   int         e_cnt;

   int         n_vec = 0;
   int         n_fail = 0;
   bit         lv_hold;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input bit lv, input int li, input bit rv, input int ri, input bit rt);
      lookup_valid  = lv;
      lookup_idx    = 5'(li);
      resolve_valid = rv;
      resolve_idx   = 5'(ri);
      resolve_taken = rt;
   endtask

   task automatic model_outputs();
      bit force_wr;
      {e_en, e_we, e_clr, e_tk, e_lr, e_rr, e_done, e_pend, m_wr, m_rd} = '0;
      e_addr = '0;
      e_cnt  = 0;
      if (rst) return;
      e_cnt  = mq.size();
      e_done = m_run;
      if (!m_run) begin
         if (!flush) begin
            e_en = 1; e_we = 1; e_clr = 1; e_addr = 5'(m_sweep);
         end
      end else begin
         force_wr = (mq.size() > 0) && ((mq.size() == QDEPTH) || (m_wait == MAX_WAIT));
         if (!flush) begin
            e_lr = !force_wr;
            e_rr = mq.size() < QDEPTH;
            if (force_wr || (mq.size() > 0 && !lookup_valid)) begin
               m_wr = 1; e_en = 1; e_we = 1; e_addr = mq[0].idx; e_tk = mq[0].taken;
            end else if (lookup_valid) begin
               m_rd = 1; e_en = 1; e_addr = lookup_idx;
            end
            if (lookup_valid && e_lr)
               foreach (mq[i]) if (mq[i].idx == lookup_idx) e_pend = 1;
         end
      end
   endtask

   task automatic check_cycle();
      #3;
      model_outputs();
      chk("bht_en", 32'(bht_en), 32'(e_en));
      if (rst) begin
         chk("rst_we", 32'(bht_we), 0);
         chk("rst_clear", 32'(bht_clear), 0);
         chk("rst_addr", 32'(bht_addr), 0);
         chk("rst_taken", 32'(bht_taken), 0);
      end else if (e_en) begin
         chk("bht_we", 32'(bht_we), 32'(e_we));
         chk("bht_addr", 32'(bht_addr), 32'(e_addr));
         if (e_we) chk("bht_clear", 32'(bht_clear), 32'(e_clr));
         if (m_wr) chk("bht_taken", 32'(bht_taken), 32'(e_tk));
      end
      chk("lookup_ready", 32'(lookup_ready), 32'(e_lr));
      chk("resolve_ready", 32'(resolve_ready), 32'(e_rr));
      chk("init_done", 32'(init_done), 32'(e_done));
      chk("q_count", 32'(q_count), 32'(e_cnt));
`ifdef BHT_PENDING_HIT_EN
      chk("lookup_pending", 32'(lookup_pending), 32'(e_pend));
`endif
   endtask

   task automatic advance();
      bit   push;
      ent_t ne;
      push = resolve_valid && e_rr;
      ne   = {resolve_idx, resolve_taken};
      @(posedge clk);
      if (rst || flush) begin
         m_run = 0; m_sweep = 0; m_wait = 0; mq.delete();
      end else if (!m_run) begin
         m_sweep++;
         if (m_sweep == ENTRIES) begin m_run = 1; m_sweep = 0; end
      end else begin
         if (m_wr || mq.size() == 0) m_wait = 0;
         else if (m_rd && m_wait < MAX_WAIT) m_wait++;
         if (m_wr) void'(mq.pop_front());
         if (push) mq.push_back(ne);
      end
      #1;
   endtask

   task automatic cyc();
      check_cycle();
      advance();
   endtask

   initial begin
      rst = 1; flush = 0; lv_hold = 0;
      drive(0, 0, 0, 0, 0);
      m_run = 0; m_sweep = 0; m_wait = 0;
      #1;
      repeat (2) cyc();
      rst = 0;

      // init sweep: clears 0..31, no grants
      for (int i = 0; i < ENTRIES; i++) begin
         check_cycle();
         chk("sweep_addr", 32'(bht_addr), 32'(i));
         chk("sweep_clear", 32'(bht_clear), 1);
         chk("sweep_readys", 32'({lookup_ready, resolve_ready}), 0);
         advance();
      end
      check_cycle();
      chk("init_done_after_sweep", 32'(init_done), 1);
      advance();

      // held lookups starve one queued write until MAX_WAIT
      drive(1, 7, 1, 3, 1);
      check_cycle();
      chk("t0_read_addr", 32'(bht_addr), 7);
      chk("t0_read_we", 32'(bht_we), 0);
      advance();
      drive(1, 7, 0, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         check_cycle();
         chk("held_read_addr", 32'(bht_addr), 7);
         chk("held_lookup_ready", 32'(lookup_ready), 1);
         advance();
      end
      check_cycle();
      chk("forced_lookup_ready", 32'(lookup_ready), 0);
      chk("forced_we", 32'(bht_we), 1);
      chk("forced_addr", 32'(bht_addr), 3);
      chk("forced_taken", 32'(bht_taken), 1);
      chk("forced_qcount", 32'(q_count), 1);
      advance();
      check_cycle();
      chk("after_pop_qcount", 32'(q_count), 0);
      advance();

      // fill FIFO under held lookups, full forces a write
      drive(1, 7, 1, 1, 1); cyc();
      drive(1, 7, 1, 2, 0); cyc();
      drive(1, 7, 1, 3, 1); cyc();
      drive(1, 7, 1, 4, 0); cyc();
      drive(1, 7, 1, 5, 1);
      check_cycle();
      chk("full_resolve_ready", 32'(resolve_ready), 0);
      chk("full_forced_addr", 32'(bht_addr), 1);
      chk("full_forced_we", 32'(bht_we), 1);
      advance();
      check_cycle();
      chk("refill_resolve_ready", 32'(resolve_ready), 1);
      chk("refill_qcount", 32'(q_count), 3);
      advance();
      drive(0, 0, 0, 0, 0);
      repeat (6) cyc();

      // no lookups: write exactly one cycle after push
      drive(0, 0, 1, 9, 0);
      check_cycle();
      chk("push_cycle_idle", 32'(bht_en), 0);
      advance();
      drive(0, 0, 0, 0, 0);
      check_cycle();
      chk("nobypass_we", 32'(bht_we), 1);
      chk("nobypass_addr", 32'(bht_addr), 9);
      chk("nobypass_taken", 32'(bht_taken), 0);
      advance();

      // queue three entries, pending-hit probes, then flush
      drive(1, 7, 1, 10, 1); cyc();
      drive(1, 7, 1, 11, 0); cyc();
      drive(1, 10, 1, 12, 1);
      check_cycle();
`ifdef BHT_PENDING_HIT_EN
      chk("pending_hit", 32'(lookup_pending), 1);
`endif
      advance();
      drive(1, 13, 0, 0, 0);
      check_cycle();
      chk("three_queued", 32'(q_count), 3);
`ifdef BHT_PENDING_HIT_EN
      chk("pending_miss", 32'(lookup_pending), 0);
`endif
      advance();
      drive(0, 0, 0, 0, 0);
      flush = 1;
      check_cycle();
      chk("flush_cycle_en", 32'(bht_en), 0);
      chk("flush_cycle_lr", 32'(lookup_ready), 0);
      chk("flush_cycle_rr", 32'(resolve_ready), 0);
      advance();
      flush = 0;
      check_cycle();
      chk("post_flush_done", 32'(init_done), 0);
      chk("post_flush_qcount", 32'(q_count), 0);
      chk("post_flush_clear", 32'(bht_clear), 1);
      chk("post_flush_addr", 32'(bht_addr), 0);
      advance();
      for (int i = 1; i < ENTRIES; i++) begin
         check_cycle();
         chk("resweep_clear", 32'(bht_clear), 1);
         advance();
      end

      // randomized traffic with occasional flush and reset
      for (int c = 0; c < 4000; c++) begin
         rst   = ($urandom_range(0, 299) == 0);
         flush = ($urandom_range(0, 79) == 0);
         if (!lv_hold) begin
            lookup_valid = ($urandom_range(0, 99) < 55);
            lookup_idx   = 5'($urandom_range(0, 15));
         end
         resolve_valid = ($urandom_range(0, 99) < 40);
         resolve_idx   = 5'($urandom_range(0, 15));
         resolve_taken = 1'($urandom_range(0, 1));
         check_cycle();
         lv_hold = lookup_valid && !e_lr && !rst;
         advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
